// File: rtl/fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_rr_arbiter: two-port round-robin arbiter sharing one in-order FPU.
// Macro FPU_ARB_STATS_EN adds per-port accept counters. Revision: 1.0
// ============================================================================
module fpu_rr_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_i,
  output logic [1:0]            gnt_o,
  input  logic [1:0][2:0][31:0] operands_i,
  input  logic [1:0][5:0]       op_i,
  input  logic [1:0][10:0]      flags_i,
  output logic [1:0]            rvalid_o,
  output logic [31:0]           rdata_o,
  output logic [4:0]            rflags_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  err_o,
  output logic                  fpu_req_o,
  input  logic                  fpu_gnt_i,
  output logic [95:0]           fpu_operands_o,
  output logic [5:0]            fpu_op_o,
  output logic [10:0]           fpu_flags_o,
  input  logic                  fpu_rvalid_i,
  input  logic [31:0]           fpu_rdata_i,
  input  logic [4:0]            fpu_rflags_i
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [31:0]           acc_cnt0_o,
  output logic [31:0]           acc_cnt1_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] tag_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q;
  logic             err_q;

  logic       full, empty;
  logic [1:0] eligible;
  logic       sel;
  logic       push, pop;
  logic       head;

  assign full  = (cnt_q == DEPTH_CNT);
  assign empty = (cnt_q == '0);

  // Reset is folded in so the combinational grant path is quiet while held.
  assign eligible = (rst_ni && (state_q == RUN) && !full) ? req_i : 2'b00;

  always_comb begin
    sel = 1'b0;
    case (eligible)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_q;
      default: sel = 1'b0;
    endcase
  end

  assign fpu_req_o      = |eligible;
  assign fpu_operands_o = operands_i[sel];
  assign fpu_op_o       = op_i[sel];
  assign fpu_flags_o    = flags_i[sel];

  always_comb begin
    gnt_o      = 2'b00;
    gnt_o[sel] = fpu_gnt_i & eligible[sel];
  end

  assign push = fpu_req_o & fpu_gnt_i;
  assign pop  = fpu_rvalid_i & ~empty;
  assign head = tag_q[rd_ptr_q];

  always_comb begin
    rvalid_o       = 2'b00;
    rvalid_o[head] = pop;
  end

  assign rdata_o  = fpu_rdata_i;
  assign rflags_o = fpu_rflags_i;
  assign err_o    = err_q;

  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

  // Owner-tag FIFO and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        last_q          <= sel;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (fpu_rvalid_i && empty) begin
        err_q <= 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN always lasts at least one cycle, even when nothing is in flight.
  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d      = RUN;
          flush_done_o = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

`ifdef FPU_ARB_STATS_EN
  logic [31:0] acc_cnt0_q, acc_cnt1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_cnt0_q <= '0;
      acc_cnt1_q <= '0;
    end else if (push) begin
      if (sel) begin
        acc_cnt1_q <= acc_cnt1_q + 32'd1;
      end else begin
        acc_cnt0_q <= acc_cnt0_q + 32'd1;
      end
    end
  end

  assign acc_cnt0_o = acc_cnt0_q;
  assign acc_cnt1_o = acc_cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fpu_rr_arbiter: directed vectors with a queue-based grant/response monitor.
// Revision: 1.0
// ============================================================================
module tb_fpu_rr_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [1:0]            req_i;
  logic [1:0]            gnt_o;
  logic [1:0][2:0][31:0] operands_i;
  logic [1:0][5:0]       op_i;
  logic [1:0][10:0]      flags_i;
  logic [1:0]            rvalid_o;
  logic [31:0]           rdata_o;
  logic [4:0]            rflags_o;
  logic                  flush_i;
  logic                  flush_done_o;
  logic                  err_o;
  logic                  fpu_req_o;
  logic                  fpu_gnt_i;
  logic [95:0]           fpu_operands_o;
  logic [5:0]            fpu_op_o;
  logic [10:0]           fpu_flags_o;
  logic                  fpu_rvalid_i;
  logic [31:0]           fpu_rdata_i;
  logic [4:0]            fpu_rflags_i;
`ifdef FPU_ARB_STATS_EN
  logic [31:0]           acc_cnt0_o, acc_cnt1_o;
`endif

  fpu_rr_arbiter #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .operands_i     (operands_i),
    .op_i           (op_i),
    .flags_i        (flags_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .rflags_o       (rflags_o),
    .flush_i        (flush_i),
    .flush_done_o   (flush_done_o),
    .err_o          (err_o),
    .fpu_req_o      (fpu_req_o),
    .fpu_gnt_i      (fpu_gnt_i),
    .fpu_operands_o (fpu_operands_o),
    .fpu_op_o       (fpu_op_o),
    .fpu_flags_o    (fpu_flags_o),
    .fpu_rvalid_i   (fpu_rvalid_i),
    .fpu_rdata_i    (fpu_rdata_i),
    .fpu_rflags_i   (fpu_rflags_i)
`ifdef FPU_ARB_STATS_EN
    ,
    .acc_cnt0_o     (acc_cnt0_o),
    .acc_cnt1_o     (acc_cnt1_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  localparam logic [95:0] OPND0 = {32'h40880000, 32'h0, 32'h0};
  localparam logic [95:0] OPND1 = {32'h3F800000, 32'h40000000, 32'h0};
  localparam logic [5:0]  OP0   = 6'h0A;
  localparam logic [5:0]  OP1   = 6'h15;
  localparam logic [10:0] FLG0  = {2'b01, 3'b000, 3'b000, 3'b010};
  localparam logic [10:0] FLG1  = {2'b00, 3'b000, 3'b000, 3'b001};

  typedef struct {
    logic [1:0] req;
    logic       fg;
    logic       rv;
    logic       fl;
    logic [1:0] egnt;
    logic [1:0] erv;
    logic       edone;
    logic       eerr;
  } vec_t;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] data;
    logic [4:0]  fl;
  } rsp_t;

  vec_t vecs[$];
  int   gnt_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   seq   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] req, input logic fg, input logic rv, input logic fl,
                     input logic [1:0] egnt, input logic [1:0] erv, input logic edone,
                     input logic eerr);
    vec_t v;
    v.req = req; v.fg = fg; v.rv = rv; v.fl = fl;
    v.egnt = egnt; v.erv = erv; v.edone = edone; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    req_i        = 2'b00;
    fpu_gnt_i    = 1'b0;
    fpu_rvalid_i = 1'b0;
    flush_i      = 1'b0;
    fpu_rdata_i  = 32'h0;
    fpu_rflags_i = 5'h0;
  endtask

  task automatic drain_check(input string tag);
    total++;
    if (gnt_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: got grants=%0d responses=%0d expected 0/0",
               tag, gnt_q.size(), rsp_q.size());
    end
    gnt_q.delete();
    rsp_q.delete();
  endtask

  // Applies each vector at posedge+1; the monitor samples at negedge.
  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      rsp_t r;
      logic [31:0] d;
      d            = 32'hC0DE0000 + 32'(seq);
      req_i        = vecs[i].req;
      fpu_gnt_i    = vecs[i].fg;
      fpu_rvalid_i = vecs[i].rv;
      flush_i      = vecs[i].fl;
      fpu_rdata_i  = d;
      fpu_rflags_i = d[4:0];
      seq++;
      if (vecs[i].egnt != 2'b00) gnt_q.push_back(vecs[i].egnt == 2'b10 ? 1 : 0);
      if (vecs[i].erv != 2'b00) begin
        r.rv = vecs[i].erv; r.data = d; r.fl = d[4:0];
        rsp_q.push_back(r);
      end
      #1;
      chk({tag, "_flush_done"}, 128'(flush_done_o), 128'(vecs[i].edone));
      chk({tag, "_err"}, 128'(err_o), 128'(vecs[i].eerr));
      chk({tag, "_fpu_req"}, 128'(fpu_req_o), 128'(vecs[i].egnt != 2'b00));
      @(posedge clk_i);
      #1;
    end
    vecs.delete();
    idle_inputs();
    drain_check(tag);
  endtask

  task automatic reset_pulse(input string tag);
    rst_ni       = 1'b0;
    req_i        = 2'b11;
    fpu_gnt_i    = 1'b1;
    fpu_rvalid_i = 1'b1;
    #1;
    chk({tag, "_rst_gnt"}, 128'(gnt_o), 128'(0));
    chk({tag, "_rst_fpu_req"}, 128'(fpu_req_o), 128'(0));
    chk({tag, "_rst_rvalid"}, 128'(rvalid_o), 128'(0));
    chk({tag, "_rst_err"}, 128'(err_o), 128'(0));
    chk({tag, "_rst_done"}, 128'(flush_done_o), 128'(0));
    @(posedge clk_i);
    #1;
    idle_inputs();
    rst_ni = 1'b1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a grant or response.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (gnt_o != 2'b00) begin
        if (gnt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got %b expected none (t=%0t)", gnt_o, $time);
        end else begin
          int p;
          p = gnt_q.pop_front();
          chk("grant", 128'(gnt_o), 128'(p == 1 ? 2'b10 : 2'b01));
          chk("operands", 128'(fpu_operands_o), 128'(p == 1 ? OPND1 : OPND0));
          chk("op", 128'(fpu_op_o), 128'(p == 1 ? OP1 : OP0));
          chk("flags", 128'(fpu_flags_o), 128'(p == 1 ? FLG1 : FLG0));
        end
      end
      if (rvalid_o != 2'b00) begin
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid: got %b expected none (t=%0t)", rvalid_o, $time);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rvalid", 128'(rvalid_o), 128'(r.rv));
          chk("rdata", 128'(rdata_o), 128'(r.data));
          chk("rflags", 128'(rflags_o), 128'(r.fl));
        end
      end
    end
  end

  initial begin
    operands_i[0] = OPND0;
    operands_i[1] = OPND1;
    op_i[0]       = OP0;
    op_i[1]       = OP1;
    flags_i[0]    = FLG0;
    flags_i[1]    = FLG1;
    idle_inputs();
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    reset_pulse("init");

    // Continuous contention with a single-cycle FPU: 0,1,0,1
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b11, 1, 1, 0, 2'b10, 2'b01, 0, 0);
    add(2'b11, 1, 1, 0, 2'b01, 2'b10, 0, 0);
    add(2'b11, 1, 1, 0, 2'b10, 2'b01, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 0);
    run_vecs("rr");

    // Fill the tag FIFO from port 1; full blocks the grant even with a pop
    for (int i = 0; i < 4; i++) add(2'b10, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    add(2'b10, 1, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b10, 1, 1, 0, 2'b00, 2'b10, 0, 0);
    add(2'b10, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) add(2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 0);
    run_vecs("full");

    // In-order responses route to their owners
    add(2'b01, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b10, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 0);
    run_vecs("order");

    // Flush with three outstanding; a second flush in DRAIN is ignored
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b11, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    add(2'b11, 1, 1, 0, 2'b00, 2'b01, 0, 0);
    add(2'b11, 1, 1, 0, 2'b00, 2'b10, 0, 0);
    add(2'b11, 1, 1, 1, 2'b00, 2'b01, 1, 0);
    add(2'b11, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 0);
    run_vecs("flush3");

    // Flush with nothing in flight still spends one cycle in DRAIN
    add(2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    add(2'b11, 1, 0, 0, 2'b00, 2'b00, 1, 0);
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0);
    run_vecs("flush0");

    // Orphan response sets the sticky error
    add(2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    run_vecs("orphan");
    reset_pulse("errclr");

    // Reset with two outstanding tags
    add(2'b10, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    add(2'b10, 1, 0, 0, 2'b10, 2'b00, 0, 0);
    run_vecs("pre_rst");
    reset_pulse("midop");
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    add(2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    run_vecs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
